// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the execute-stage controller and the
// multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, funct, src_a, src_b,
    input  busy, done, stall, hi, lo, rd_data
  );

  modport slave (
    input  start, funct, src_a, src_b,
    output busy, done, stall, hi, lo, rd_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers. One shift-add or
// restoring shift-subtract step per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // mul: {partial hi, multiplier/lo}; div: {rem, quo}
  logic [WIDTH-1:0]     opa_q;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     raw_a_q;        // unmodified dividend for divide-by-zero HI
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;
  logic                 is_div_q, sgn_q, sign_a_q, sign_b_q, div0_q;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    op_signed, op_mul;
  logic [WIDTH:0]          mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]      prod;
  logic [WIDTH-1:0]        res_hi, res_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    return (is_signed && v < 0) ? neg_w(v) : v;
  endfunction

  assign a_s       = bus.src_a;
  assign b_s       = bus.src_b;
  assign op_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign op_mul    = (bus.funct == F_MULT) || (bus.funct == F_MULTU);

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide).
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : '0)};
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, opa_q};
    if (!is_div_q) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction of the unsigned result; divide-by-zero bypasses it.
  always_comb begin
    prod   = acc_q;
    res_hi = '0;
    res_lo = '0;
    if (!is_div_q) begin
      if (sgn_q && (sign_a_q ^ sign_b_q)) prod = neg_2w(acc_q);
      {res_hi, res_lo} = prod;
    end else if (div0_q) begin
      res_hi = raw_a_q;
      res_lo = '1;
    end else begin
      res_lo = (sgn_q && (sign_a_q ^ sign_b_q)) ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      res_hi = (sgn_q && sign_a_q) ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with operand capture, iteration and HI/LO write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      raw_a_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            case (bus.funct)
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                is_div_q <= !op_mul;
                sgn_q    <= op_signed;
                sign_a_q <= op_signed && (a_s < 0);
                sign_b_q <= op_signed && (b_s < 0);
                raw_a_q  <= bus.src_a;
                div0_q   <= (bus.src_b == '0);
                opa_q    <= op_mul ? mag(a_s, op_signed) : mag(b_s, op_signed);
                acc_q    <= {{WIDTH{1'b0}}, (op_mul ? mag(b_s, op_signed) : mag(a_s, op_signed))};
                cnt_q    <= CW'(WIDTH);
                state_q  <= CALC;
              end
              F_MTHI:  hi_q <= bus.src_a;
              F_MTLO:  lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.stall   = bus.busy && (bus.start || bus.funct == F_MFHI || bus.funct == F_MFLO);
  assign bus.rd_data = (bus.funct == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 32-bit and 8-bit instances.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) b32();
  muldiv_unit_if #(.WIDTH(8))  b8();

  muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   done_seen32 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the 32-bit unit: pop and compare on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b32.done === 1'b1) begin
        done_seen32++;
        if (q32.size() == 0) begin
          n_total++;
          $display("FAIL w32_unexpected_done: got done=1 expected no pending op");
        end else begin
          e = q32.pop_front();
          check("w32_hi", b32.hi, e.hi);
          check("w32_lo", b32.lo, e.lo);
          check("w32_latency", cyc - e.cyc, 33);
        end
      end
    end
  end

  // Monitor for the 8-bit unit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b8.done === 1'b1) begin
        if (q8.size() == 0) begin
          n_total++;
          $display("FAIL w8_unexpected_done: got done=1 expected no pending op");
        end else begin
          e = q8.pop_front();
          check("w8_hi", b8.hi, e.hi);
          check("w8_lo", b8.lo, e.lo);
          check("w8_latency", cyc - e.cyc, 9);
        end
      end
    end
  end

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    b32.start = 1'b1;
    b32.funct = f;
    b32.src_a = a;
    b32.src_b = b;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.cyc = cyc + 1;
      q32.push_back(e);
    end
    @(posedge clk); #1;
    b32.start = 1'b0;
    b32.funct = 6'h00;
  endtask

  task automatic wait_done32(output int busy_cycles);
    bit got;
    got = 0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b32.busy === 1'b1) busy_cycles++;
      if (b32.done === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL w32_done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  initial begin
    int bc;
    int d0;
    bit got8;
    exp_t e;
    b32.start = 1'b0; b32.funct = 6'h00; b32.src_a = '0; b32.src_b = '0;
    b8.start  = 1'b0; b8.funct  = 6'h00; b8.src_a  = '0; b8.src_b  = '0;

    #12;
    check("rst_busy", b32.busy, 0);
    check("rst_done", b32.done, 0);
    check("rst_hi",   b32.hi,   0);
    check("rst_lo",   b32.lo,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MULTU full-scale
    drive(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done32(bc);
    check("multu_busy_cycles", bc, 33);

    // MULT -3*7, then DIV -7/2 issued in the done cycle
    @(posedge clk); #1;
    drive(6'h18, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done32(bc);
    drive(6'h1A, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done32(bc);
    check("div_b2b_busy_cycles", bc, 33);

    // Divide by zero and signed overflow
    drive(6'h1B, 32'd5, 32'd0, 1, 32'h0000_0005, 32'hFFFF_FFFF);
    wait_done32(bc);
    drive(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000);
    wait_done32(bc);

    // MTHI while busy is ignored and stalls
    drive(6'h19, 32'd2, 32'd3, 1, 32'h0, 32'd6);
    b32.start = 1'b1; b32.funct = 6'h11; b32.src_a = 32'h1234;
    #1;
    check("busy_mthi_stall", b32.stall, 1);
    @(posedge clk); #1;
    b32.start = 1'b0; b32.funct = 6'h00;
    check("busy_mthi_hi_kept", b32.hi, 32'h0);
    check("busy_lo_kept", b32.lo, 32'h8000_0000);
    wait_done32(bc);

    // MTHI / MTLO in IDLE, read back via rd_data
    drive(6'h11, 32'h1234, 32'h0, 0, 32'h0, 32'h0);
    check("mthi_hi", b32.hi, 32'h1234);
    b32.start = 1'b1; b32.funct = 6'h10;
    #1;
    check("mfhi_rd_data", b32.rd_data, 32'h1234);
    check("mfhi_stall", b32.stall, 0);
    b32.start = 1'b0;
    @(posedge clk); #1;
    drive(6'h13, 32'h55AA, 32'h0, 0, 32'h0, 32'h0);
    b32.funct = 6'h12;
    #1;
    check("mflo_rd_data", b32.rd_data, 32'h55AA);
    b32.funct = 6'h00;

    // Reset in the middle of a DIVU
    drive(6'h1B, 32'd100, 32'd7, 0, 32'h0, 32'h0);
    repeat (10) @(negedge clk);
    d0 = done_seen32;
    rst_n = 1'b0;
    #1;
    check("abort_busy", b32.busy, 0);
    check("abort_done", b32.done, 0);
    check("abort_hi",   b32.hi,   0);
    check("abort_lo",   b32.lo,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_seen32, d0);
    check("abort_idle_busy", b32.busy, 0);

    // 8-bit instance: MULTU 0xFF * 0x02
    @(posedge clk); #1;
    b8.start = 1'b1; b8.funct = 6'h19; b8.src_a = 8'hFF; b8.src_b = 8'h02;
    e.hi = 32'h01; e.lo = 32'hFE; e.cyc = cyc + 1;
    q8.push_back(e);
    @(posedge clk); #1;
    b8.start = 1'b0; b8.funct = 6'h00;
    got8 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b8.done === 1'b1) begin
        got8 = 1;
        break;
      end
    end
    if (!got8) begin
      n_total++;
      $display("FAIL w8_done_timeout: got no done expected done within 40 cycles");
    end

    repeat (3) @(negedge clk);
    check("w32_queue_drained", q32.size(), 0);
    check("w8_queue_drained", q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers, next generation of the ALU control path: decodes the R-type `funct` field for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and executes multiply/divide over multiple cycles. It sits in the execute stage beside the ALU and is driven from `alu_op == 2'b10` R-type decode. It exposes a busy/stall handshake to the controller. Operand width is parametrised.

## Interface
- `WIDTH`, 32, operand width; product/remainder held as HI (upper/remainder) and LO (lower/quotient). Legal range WIDTH >= 2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; meaningful only when `funct` is one of the eight codes below.
- `funct` in 6: FUNCT code. MFHI=0x10, MTHI=0x11, MFLO=0x12, MTLO=0x13, MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B.
- `src_a` in WIDTH: multiplicand/dividend; source for MTHI/MTLO.
- `src_b` in WIDTH: multiplier/divisor.
- `busy` out 1: operation in flight (state != IDLE).
- `done` out 1: one-cycle pulse; HI/LO hold new result.
- `stall` out 1: combinational; `busy & (start | funct==MFHI | funct==MFLO)`.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `rd_data` out WIDTH: combinational; `hi` when `funct==MFHI`, else `lo`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start` and MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes. Signed ops take absolute values and record the sign of `src_a` and `src_b`.
  - Load counter = WIDTH and go to CALC.
- IDLE with `start` and MTHI/MTLO: `hi`/`lo` <= `src_a` at the next edge. No busy, no done.
- IDLE with `start` and MFHI/MFLO: no state change; read data comes from `rd_data`.
- CALC performs one iteration per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - Counter decrements each cycle; at 1, go to FIX.
- FIX:
  - Sign correction. Signed multiply negates the product if sign_a^sign_b. Signed divide negates the quotient if sign_a^sign_b and the remainder if sign_a.
  - Write HI/LO, pulse `done`, return to IDLE.
- Divisor zero (DIV or DIVU): LO = all ones, HI = `src_a` raw, with no sign correction and no exception.
- Signed overflow, most-negative / -1: LO = most-negative, HI = 0. This falls out of unsigned magnitude plus wrap-around negate; no special case.
- `start` while busy is ignored entirely, with no queuing. The controller must hold the instruction while `stall` is high.
- Unlisted `funct` with `start`: no effect.
- All arithmetic is modulo 2^WIDTH per register. The counter is $clog2(WIDTH+1) bits.

## Timing
- Reset, asynchronous: state IDLE, counter 0, `hi`=`lo`=0, `busy`=0, `done`=0, accumulators 0.
- Deassertion is synchronised by the standard top-level reset logic.
- Start sampled at edge E0.
  - `busy` is high after E0 through E(WIDTH+1): WIDTH cycles CALC, 1 cycle FIX.
  - At E(WIDTH+1), `hi`/`lo` update, `done`=1 and `busy`=0.
  - Latency start-edge to done-visible is WIDTH+1 cycles; 33 for WIDTH=32.
- `done` lasts exactly one cycle.
- A new `start` in the `done` cycle is accepted (back-to-back, no bubble).
- MTHI/MTLO take effect at the sampling edge; readable via `rd_data` the following cycle.
- `rd_data` and `stall` are combinational with no registered delay.
- During busy, `hi`/`lo` keep their previous values until E(WIDTH+1).
- Reset mid-operation aborts immediately: no `done`, and `hi`/`lo` are cleared.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; `done` exactly 33 cycles after start edge; `busy` high 33 cycles.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV -7 / 2 issued in the `done` cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=0x00000005. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 while busy -> ignored and `stall`=1. Same MTHI in IDLE -> hi=0x1234 next cycle; MFHI `rd_data`=0x1234 with `stall`=0.
- `rst_n` low at cycle 10 of a DIVU -> `busy`, `done`, `hi`, `lo` all 0 immediately; no `done` pulse after release.
- WIDTH=8 build: MULTU 0xFF × 0x02 -> hi=0x01, lo=0xFE; `done` 9 cycles after start.
